// File: rtl/clarvi_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// clarvi_mem_arbiter_pkg
// Shared types for the CLARVI memory arbiter.
//   arb_state_t  : arbiter lock states (IDLE, LOCK_INSTR, LOCK_MAIN)
//   arb_source_t : read-response source tag; SRC_MAIN is encoded as 1 so a
//                  1-bit "main granted" flag doubles as the tag value.
// -----------------------------------------------------------------------------
package clarvi_mem_arbiter_pkg;

    localparam int AVM_DATA_W = 64;
    localparam int AVM_BE_W   = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_MAIN  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_MAIN  = 1'b1
    } arb_source_t;

endpackage

// File: rtl/clarvi_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// clarvi_mem_arbiter_if
// Avalon-MM style bus bundle used for the fetch port, the data port and the
// shared memory master port.
//   address/read/write/writedata/byteenable : request, driven by the master
//   waitrequest/readdata/readdatavalid      : handshake and pipelined response,
//                                             driven by the slave
// Modports: master (issues requests), slave (accepts requests).
// -----------------------------------------------------------------------------
interface clarvi_mem_arbiter_if
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [AVM_DATA_W-1:0] writedata;
    logic [AVM_BE_W-1:0]   byteenable;
    logic                  waitrequest;
    logic [AVM_DATA_W-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/clarvi_tag_fifo.sv
// -----------------------------------------------------------------------------
// clarvi_tag_fifo
// In-order FIFO of 1-bit source tags for outstanding reads. Shift-register
// organisation: the head is always entry 0.
//   clock, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_tag  : enqueue a tag (ignored when full unless popping too)
//   i_pop          : dequeue the head (ignored when empty)
//   o_head         : tag at the head (meaningless when empty)
//   o_full/o_empty/o_count : occupancy
// -----------------------------------------------------------------------------
module clarvi_tag_fifo #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_tag,
    input  logic             i_pop,
    output logic             o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic             r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    int               w_wr_idx;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_pop    = i_pop & ~o_empty;
    assign w_push   = i_push & (~o_full | w_pop);
    // A same-edge pop shifts everything down, so the new tag lands one lower.
    assign w_wr_idx = int'(r_count) - int'(w_pop);
    assign o_head   = r_mem[0];
    assign o_count  = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; only r_count qualifies its contents.
    always_ff @(posedge clock) begin
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_mem[i] <= r_mem[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (i == w_wr_idx)) begin
                r_mem[i] <= i_tag;
            end
        end
    end
endmodule

// File: rtl/clarvi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// clarvi_mem_arbiter
// Arbitrates the CLARVI fetch port and data port onto one Avalon-MM master.
// Requests pass through combinationally; a request stalled by avm waitrequest
// locks the bus to its owner until accepted. Read responses are routed back
// in order using a tag FIFO of depth MAX_PENDING.
//   clock, reset_n  : clock, asynchronous active-low reset
//   instr (slave)   : fetch port, read-only (write/writedata/byteenable unused)
//   main  (slave)   : data port, reads and writes
//   avm   (master)  : shared memory bus
//   protocol_error  : sticky flag (lock owner dropped request, response with
//                     nothing outstanding, simultaneous read+write on main)
// Build option: CLARVI_ARB_ROUND_ROBIN_EN selects round-robin between
// simultaneous requests; otherwise main has fixed priority.
// -----------------------------------------------------------------------------
module clarvi_mem_arbiter
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int MAX_PENDING = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    clarvi_mem_arbiter_if.slave   instr,
    clarvi_mem_arbiter_if.slave   main,
    clarvi_mem_arbiter_if.master  avm,
    output logic                  protocol_error
);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  r_protocol_error;
    logic                  w_main_req;
    logic                  w_main_rd;
    logic                  w_read_block;
    logic                  w_instr_elig;
    logic                  w_main_elig;
    logic                  w_grant_instr;
    logic                  w_grant_main;
    logic                  w_drop;
    logic                  w_accept;
    logic                  w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_rsp_valid;
    logic [ADDR_WIDTH-1:0] w_avm_address;
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
    arb_source_t           r_prio;
`endif

    // The fetch port never writes; fold its write-side signals into a sink.
    wire w_unused = ^{instr.write, instr.writedata, instr.byteenable, w_fifo_full};

    // A read+write on main is treated as a write; the read half is dropped.
    assign w_main_rd    = main.read & ~main.write;
    assign w_main_req   = main.read | main.write;
    assign w_read_block = (w_fifo_count == CNT_W'(MAX_PENDING));
    assign w_instr_elig = instr.read & ~w_read_block;
    assign w_main_elig  = main.write | (w_main_rd & ~w_read_block);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_instr = 1'b0;
        w_grant_main  = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_instr_elig && w_main_elig) begin
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
                    w_grant_instr = (r_prio == SRC_INSTR);
                    w_grant_main  = (r_prio == SRC_MAIN);
`else
                    w_grant_main  = 1'b1;
`endif
                end else begin
                    w_grant_instr = w_instr_elig;
                    w_grant_main  = w_main_elig;
                end
                if (w_grant_instr && avm.waitrequest) w_state_next = LOCK_INSTR;
                if (w_grant_main && avm.waitrequest)  w_state_next = LOCK_MAIN;
            end
            LOCK_INSTR: begin
                if (!instr.read) begin
                    w_drop       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_grant_instr = w_instr_elig;
                    if (w_instr_elig && !avm.waitrequest) w_state_next = IDLE;
                end
            end
            LOCK_MAIN: begin
                if (!w_main_req) begin
                    w_drop       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_grant_main = w_main_elig;
                    if (w_main_elig && !avm.waitrequest) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept        = (w_grant_instr | w_grant_main) & ~avm.waitrequest;
    assign w_avm_address   = w_grant_instr ? instr.address : main.address;
    assign avm.address     = w_avm_address;
    assign avm.read        = w_grant_instr | (w_grant_main & w_main_rd);
    assign avm.write       = w_grant_main & main.write;
    assign avm.writedata   = main.writedata;
    assign avm.byteenable  = main.byteenable;
    assign instr.waitrequest = ~(w_grant_instr & w_accept);
    assign main.waitrequest  = ~(w_grant_main & w_accept);

    // Tag value equals w_grant_main because SRC_MAIN is encoded as 1.
    clarvi_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_accept & avm.read),
        .i_tag   (w_grant_main),
        .i_pop   (avm.readdatavalid),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_rsp_valid         = avm.readdatavalid & ~w_fifo_empty;
    assign instr.readdata      = avm.readdata;
    assign main.readdata       = avm.readdata;
    assign instr.readdatavalid = w_rsp_valid & (arb_source_t'(w_fifo_head) == SRC_INSTR);
    assign main.readdatavalid  = w_rsp_valid & (arb_source_t'(w_fifo_head) == SRC_MAIN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_protocol_error <= 1'b0;
        end else if (w_drop || (avm.readdatavalid && w_fifo_empty) ||
                     (w_accept && w_grant_main && main.read && main.write)) begin
            r_protocol_error <= 1'b1;
        end
    end
    assign protocol_error = r_protocol_error;

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
    // Pointer names the requester preferred at the next simultaneous request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= SRC_MAIN;
        end else if (w_accept) begin
            r_prio <= w_grant_main ? SRC_INSTR : SRC_MAIN;
        end
    end
`endif
endmodule

// File: doc/clarvi_mem_arbiter.md
CLARVI_MEM_ARBITER -- requirements
Module: clarvi_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: word-address width on all ports.
REQ-002 Parameter MAX_PENDING, default 2: maximum outstanding reads on avm port (1..4).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 instr_address / instr_read  input  ADDR_WIDTH / 1  fetch read request.
REQ-006 instr_waitrequest  output  1  high = fetch request not accepted this cycle.
REQ-007 instr_readdata / instr_readdatavalid  output  64 / 1  fetch response.
REQ-008 main_address / main_read / main_write  input  ADDR_WIDTH / 1 / 1  data-port request.
REQ-009 main_writedata / main_byteenable  input  64 / 8  store data and lane enables.
REQ-010 main_waitrequest  output  1  high = data request not accepted this cycle.
REQ-011 main_readdata / main_readdatavalid  output  64 / 1  load response.
REQ-012 avm_address / avm_read / avm_write / avm_writedata / avm_byteenable  output  ADDR_WIDTH / 1 / 1 / 64 / 8  shared Avalon-MM master.
REQ-013 avm_waitrequest / avm_readdata / avm_readdatavalid  input  1 / 64 / 1  slave handshake and pipelined response.
REQ-014 protocol_error  output  1  sticky error flag.

Function
REQ-015 Pass-through is combinational: granted request drives avm_* in same cycle; accepted when granted && !avm_waitrequest.
REQ-016 FSM states IDLE, LOCK_INSTR, LOCK_MAIN; from IDLE, granted request with avm_waitrequest high -> LOCK_<owner>; LOCK_x -> IDLE on acceptance.
REQ-017 In LOCK_x only owner x is granted, regardless of other requests or priority.
REQ-018 Owner dropping its request while locked: lock released next cycle, protocol_error set.
REQ-019 Read issue blocked (no avm_read, requester waitrequest high) while pending count == MAX_PENDING, even if a response retires that cycle; writes never blocked by pending count.
REQ-020 Each accepted read pushes source tag (INSTR/MAIN) into in-order tag FIFO, depth MAX_PENDING.
REQ-021 avm_readdata broadcast to both readdata outputs; avm_readdatavalid routed to instr_ or main_readdatavalid by FIFO head, head popped same edge.
REQ-022 Simultaneous push and pop: both occur, count unchanged.
REQ-023 avm_readdatavalid with FIFO empty: response dropped, protocol_error set.
REQ-024 main_read && main_write together: write issued, read ignored, protocol_error set.
REQ-025 Non-granted requester sees waitrequest high; idle requester sees waitrequest high.

Reset
REQ-026 reset_n low: FSM IDLE, FIFO empty, protocol_error 0, priority pointer to MAIN; all avm_* strobes and readdatavalid outputs 0 combinationally while requests absent.
REQ-027 Reset mid-transfer discards pending tags; responses arriving after reset follow REQ-023.

Configuration
REQ-028 CLARVI_ARB_ROUND_ROBIN_EN defined: from IDLE, requester not granted at last acceptance wins simultaneous requests; pointer updates on each acceptance.
REQ-029 Macro undefined: fixed priority, main always wins simultaneous requests from IDLE.

Structure
REQ-030 Shared package (riscv.svh): arb_state_t enum and arb_source_t {SRC_INSTR, SRC_MAIN}.
REQ-031 Tag FIFO is sub-module clarvi_tag_fifo (parameter DEPTH, 1-bit payload, full/empty/count).

Verification
REQ-032 Both read at 0x10/0x20, waitrequest 0, no RR: main accepted cycle 0, instr cycle 1; responses A,B route main then instr.
REQ-033 RR build, 4 cycles both requesting: grants alternate M,I,M,I.
REQ-034 avm_waitrequest high 3 cycles on instr read, main asserts cycle 1: avm_address holds instr address until accept, then main granted.
REQ-035 MAX_PENDING=2, three back-to-back reads, no response: third held with waitrequest until first readdatavalid seen, then issued next cycle.
REQ-036 Spurious avm_readdatavalid at reset idle -> both readdatavalid 0, protocol_error 1 until reset_n low.
REQ-037 reset_n low with 2 reads pending, release, then 2 responses -> both dropped, protocol_error 1.
